// File: rtl/disp_7seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment codes are in active-high form, bit order {g,f,e,d,c,b,a}.
package disp_7seg_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned DIG_W = 4;

   localparam logic [SEG_W-1:0] CODE_0     = 7'b0111111;
   localparam logic [SEG_W-1:0] CODE_1     = 7'b0000110;
   localparam logic [SEG_W-1:0] CODE_2     = 7'b1011011;
   localparam logic [SEG_W-1:0] CODE_3     = 7'b1001111;
   localparam logic [SEG_W-1:0] CODE_4     = 7'b1100110;
   localparam logic [SEG_W-1:0] CODE_5     = 7'b1101101;
   localparam logic [SEG_W-1:0] CODE_6     = 7'b1111101;
   localparam logic [SEG_W-1:0] CODE_7     = 7'b0000111;
   localparam logic [SEG_W-1:0] CODE_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] CODE_9     = 7'b1101111;
   localparam logic [SEG_W-1:0] CODE_A     = 7'b1110111;
   localparam logic [SEG_W-1:0] CODE_B     = 7'b1111100;
   localparam logic [SEG_W-1:0] CODE_C     = 7'b0111001;
   localparam logic [SEG_W-1:0] CODE_D     = 7'b1011110;
   localparam logic [SEG_W-1:0] CODE_E     = 7'b1111001;
   localparam logic [SEG_W-1:0] CODE_F     = 7'b1110001;
   localparam logic [SEG_W-1:0] CODE_DASH  = 7'b1000000;
   localparam logic [SEG_W-1:0] CODE_BLANK = 7'b0000000;

   // Full hex glyph lookup; decimal-only substitution is done by the encoder.
   function automatic logic [SEG_W-1:0] hex_code(input logic [DIG_W-1:0] v);
      logic [SEG_W-1:0] c;
      c = CODE_BLANK;
      case (v)
         4'h0: c = CODE_0;
         4'h1: c = CODE_1;
         4'h2: c = CODE_2;
         4'h3: c = CODE_3;
         4'h4: c = CODE_4;
         4'h5: c = CODE_5;
         4'h6: c = CODE_6;
         4'h7: c = CODE_7;
         4'h8: c = CODE_8;
         4'h9: c = CODE_9;
         4'hA: c = CODE_A;
         4'hB: c = CODE_B;
         4'hC: c = CODE_C;
         4'hD: c = CODE_D;
         4'hE: c = CODE_E;
         4'hF: c = CODE_F;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational digit encoder: 4-bit value -> active-high 7-segment code.
module seg7_hex_enc
   import disp_7seg_pkg::*;
(
   input  logic [DIG_W-1:0] value,
   input  logic             hex_mode,
   input  logic             blank,
   output logic [SEG_W-1:0] code
);

   // Blank wins; codes above 9 become a dash unless hex glyphs are enabled.
   always_comb begin
      code = CODE_BLANK;
      if (blank) begin
         code = CODE_BLANK;
      end else if (!hex_mode && (value > 4'd9)) begin
         code = CODE_DASH;
      end else begin
         code = hex_code(value);
      end
   end

endmodule

// File: rtl/disp_7seg_scan.sv
// Multiplexed N-digit 7-segment driver: shadowed digit values, programmable
// scan rate, leading-zero blanking, decimal points and per-slot dead time.
module disp_7seg_scan
   import disp_7seg_pkg::*;
#(
   parameter int unsigned N_DIGIT     = 4,
   parameter int unsigned SCAN_DIV    = 50000,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          AN_ACT_LOW  = 1'b1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [4*N_DIGIT-1:0]   DIN,
   input  logic [N_DIGIT-1:0]     DP_IN,
   input  logic                   LOAD,
   input  logic                   HEX_MODE,
   input  logic                   LZ_BLANK,
   output logic [SEG_W-1:0]       SEG,
   output logic                   SEG_DP,
   output logic [N_DIGIT-1:0]     AN
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;

   // XOR masks; the inactive output level equals the mask itself.
   localparam logic [SEG_W-1:0]   SEG_INV = {SEG_W{SEG_ACT_LOW}};
   localparam logic               DP_INV  = SEG_ACT_LOW;
   localparam logic [N_DIGIT-1:0] AN_INV  = {N_DIGIT{AN_ACT_LOW}};

   logic [CNT_W-1:0]              cnt_q;
   logic [IDX_W-1:0]              idx_q;
   logic [N_DIGIT-1:0][DIG_W-1:0] dig_q;
   logic [N_DIGIT-1:0]            dp_q;

   logic [SEG_W-1:0]   seg_q;
   logic               seg_dp_q;
   logic [N_DIGIT-1:0] an_q;

   logic [N_DIGIT-1:0] lz_mask;
   logic               upper_zero;
   logic [DIG_W-1:0]   sel_val;
   logic               sel_dp;
   logic               sel_blank;
   logic [N_DIGIT-1:0] an_d;
   logic [SEG_W-1:0]   seg_code;

   // Slot counter and digit index; index advances when the counter wraps.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_q <= '0;
         idx_q <= (idx_q == IDX_W'(N_DIGIT - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Shadow registers for digit values and decimal points.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dig_q <= '0;
         dp_q  <= '0;
      end else if (LOAD) begin
         dig_q <= DIN;
         dp_q  <= DP_IN;
      end
   end

   // Leading-zero mask (top-down zero run), digit select and anode pattern.
   always_comb begin
      lz_mask    = '0;
      upper_zero = 1'b1;
      sel_val    = '0;
      sel_dp     = 1'b0;
      sel_blank  = 1'b0;
      an_d       = '0;
      for (int i = int'(N_DIGIT) - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (dig_q[i] == '0);
         lz_mask[i] = LZ_BLANK && (i != 0) && upper_zero;
      end
      for (int unsigned i = 0; i < N_DIGIT; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_val   = dig_q[i];
            sel_dp    = dp_q[i];
            sel_blank = lz_mask[i];
            an_d[i]   = (cnt_q != '0);  // dead time on the first cycle of a slot
         end
      end
   end

   seg7_hex_enc u_enc (
      .value    (sel_val),
      .hex_mode (HEX_MODE),
      .blank    (sel_blank),
      .code     (seg_code)
   );

   // Output registers with board polarity applied.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         seg_q    <= SEG_INV;
         seg_dp_q <= DP_INV;
         an_q     <= AN_INV;
      end else begin
         seg_q    <= seg_code ^ SEG_INV;
         seg_dp_q <= sel_dp ^ DP_INV;
         an_q     <= an_d ^ AN_INV;
      end
   end

   assign SEG    = seg_q;
   assign SEG_DP = seg_dp_q;
   assign AN     = an_q;

endmodule

// File: tb/tb_disp_7seg_scan.sv
// Directed bench for disp_7seg_scan: a 4-digit active-low instance and a
// 1-digit active-high instance, both with a 4-cycle scan slot.
module tb_disp_7seg_scan;

   logic        CLK;
   logic        RST;
   logic [15:0] DIN;
   logic [3:0]  DP_IN;
   logic        LOAD;
   logic        HEX_MODE;
   logic        LZ_BLANK;
   logic [6:0]  SEG;
   logic        SEG_DP;
   logic [3:0]  AN;

   logic [3:0]  din1;
   logic [0:0]  dp1;
   logic [6:0]  seg1;
   logic        seg_dp1;
   logic [0:0]  an1;

   int checks = 0;
   int errors = 0;

   disp_7seg_scan #(
      .N_DIGIT     (4),
      .SCAN_DIV    (4),
      .SEG_ACT_LOW (1'b1),
      .AN_ACT_LOW  (1'b1)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .DIN      (DIN),
      .DP_IN    (DP_IN),
      .LOAD     (LOAD),
      .HEX_MODE (HEX_MODE),
      .LZ_BLANK (LZ_BLANK),
      .SEG      (SEG),
      .SEG_DP   (SEG_DP),
      .AN       (AN)
   );

   disp_7seg_scan #(
      .N_DIGIT     (1),
      .SCAN_DIV    (4),
      .SEG_ACT_LOW (1'b0),
      .AN_ACT_LOW  (1'b0)
   ) dut1 (
      .CLK      (CLK),
      .RST      (RST),
      .DIN      (din1),
      .DP_IN    (dp1),
      .LOAD     (LOAD),
      .HEX_MODE (HEX_MODE),
      .LZ_BLANK (LZ_BLANK),
      .SEG      (seg1),
      .SEG_DP   (seg_dp1),
      .AN       (an1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic chk(input string tag, input logic [6:0] es, input logic edp,
                      input logic [3:0] ean);
      checks++;
      assert (SEG === es && SEG_DP === edp && AN === ean)
      else begin
         errors++;
         $error("FAIL %s: seg=%b dp=%b an=%b, expected seg=%b dp=%b an=%b",
                tag, SEG, SEG_DP, AN, es, edp, ean);
      end
   endtask

   task automatic chk1(input string tag, input logic [6:0] es, input logic edp,
                       input logic ean);
      checks++;
      assert (seg1 === es && seg_dp1 === edp && an1[0] === ean)
      else begin
         errors++;
         $error("FAIL %s: seg=%b dp=%b an=%b, expected seg=%b dp=%b an=%b",
                tag, seg1, seg_dp1, an1, es, edp, ean);
      end
   endtask

   initial begin
      RST = 1'b0; LOAD = 1'b0; DIN = '0; DP_IN = '0;
      HEX_MODE = 1'b0; LZ_BLANK = 1'b0; din1 = '0; dp1 = '0;
      #1 RST = 1'b1;
      steps(2);
      chk("reset", 7'h7F, 1'b1, 4'hF);
      chk1("n1_reset", 7'h00, 1'b0, 1'b0);

      // Basic scan of 1234
      RST = 1'b0; LOAD = 1'b1; DIN = 16'h1234;
      step(); LOAD = 1'b0;
      chk("first_dead", 7'b1000000, 1'b1, 4'hF);
      chk1("n1_dead", 7'b0111111, 1'b0, 1'b0);
      step();
      chk("d0_4", 7'b0011001, 1'b1, 4'b1110);
      chk1("n1_lit", 7'b0111111, 1'b0, 1'b1);
      steps(3);
      chk("d1_dead", 7'b0110000, 1'b1, 4'hF);
      chk1("n1_dead2", 7'b0111111, 1'b0, 1'b0);
      step();
      chk("d1_3", 7'b0110000, 1'b1, 4'b1101);
      chk1("n1_lit2", 7'b0111111, 1'b0, 1'b1);
      steps(3);
      chk("d2_dead", 7'b0100100, 1'b1, 4'hF);
      step();
      chk("d2_2", 7'b0100100, 1'b1, 4'b1011);
      steps(3);
      chk("d3_dead", 7'b1111001, 1'b1, 4'hF);
      step();
      chk("d3_1", 7'b1111001, 1'b1, 4'b0111);
      steps(2);

      // 00A5 with leading-zero blanking, dash then hex A
      DIN = 16'h00A5; LOAD = 1'b1; LZ_BLANK = 1'b1;
      step(); LOAD = 1'b0;
      chk("lz_old_d0", 7'b0011001, 1'b1, 4'hF);
      step();
      chk("d0_5", 7'b0010010, 1'b1, 4'b1110);
      steps(3);
      chk("d1_dash_dead", 7'b0111111, 1'b1, 4'hF);
      step();
      chk("d1_dash", 7'b0111111, 1'b1, 4'b1101);
      HEX_MODE = 1'b1;
      step();
      chk("d1_hex_a", 7'b0001000, 1'b1, 4'b1101);
      steps(2);
      chk("d2_blank_dead", 7'h7F, 1'b1, 4'hF);
      step();
      chk("d2_blank", 7'h7F, 1'b1, 4'b1011);
      steps(4);
      chk("d3_blank", 7'h7F, 1'b1, 4'b0111);
      steps(2);

      // All zero with a decimal point on a blanked digit
      DIN = 16'h0000; DP_IN = 4'b0100; LOAD = 1'b1;
      step(); LOAD = 1'b0;
      step();
      chk("zero_d0", 7'b1000000, 1'b1, 4'b1110);
      steps(7);
      chk("dp_blank_dead", 7'h7F, 1'b0, 4'hF);
      step();
      chk("dp_blank_lit", 7'h7F, 1'b0, 4'b1011);
      steps(2);

      // LOAD on the first (dead) cycle of digit 3's slot
      LZ_BLANK = 1'b0; DIN = 16'h9876; DP_IN = 4'b0000; LOAD = 1'b1;
      step(); LOAD = 1'b0;
      chk("load_old", 7'b1000000, 1'b1, 4'hF);
      step();
      chk("load_new", 7'b0010000, 1'b1, 4'b0111);
      steps(3);
      chk("d0_6_dead", 7'b0000010, 1'b1, 4'hF);
      step();
      chk("d0_6", 7'b0000010, 1'b1, 4'b1110);
      steps(8);
      chk("d2_8", 7'b0000000, 1'b1, 4'b1011);

      // Asynchronous reset mid-slot of digit 2
      #2 RST = 1'b1;
      #1;
      chk("rst_async", 7'h7F, 1'b1, 4'hF);
      chk1("n1_rst_async", 7'h00, 1'b0, 1'b0);
      step();
      chk("rst_held", 7'h7F, 1'b1, 4'hF);
      RST = 1'b0;
      step();
      chk("post_rst_dead", 7'b1000000, 1'b1, 4'hF);
      chk1("n1_post_dead", 7'b0111111, 1'b0, 1'b0);
      step();
      chk("post_rst_d0", 7'b1000000, 1'b1, 4'b1110);
      chk1("n1_post_lit", 7'b0111111, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/disp_7seg_scan.md
# disp_7seg_scan

Multiplexed N-digit 7-segment display driver. Holds a BCD/hex value, scans one digit at a time at a programmable rate, and drives shared segment lines plus per-digit anode enables. Adds hex mode, leading-zero blanking, decimal points and inter-digit dead time. Sits between the BER counter/status logic and the board display pins.

## Interface
- N_DIGIT, 4, number of digits scanned (1..8)
- SCAN_DIV, 50000, CLK cycles per digit slot (>= 2)
- SEG_ACT_LOW, 1, 1: segment outputs active-low; 0: active-high
- AN_ACT_LOW, 1, 1: anode outputs active-low; 0: active-high
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- DIN  in  4*N_DIGIT  digit values, digit 0 = DIN[3:0] (least significant, rightmost)
- DP_IN  in  N_DIGIT  decimal point per digit, 1 = lit
- LOAD  in  1  capture DIN/DP_IN into shadow registers
- HEX_MODE  in  1  1: codes 10..15 shown as A b C d E F; 0: shown as '-'
- LZ_BLANK  in  1  1: suppress leading zeros
- SEG  out  7  segments {g,f,e,d,c,b,a}
- SEG_DP  out  1  decimal point segment
- AN  out  N_DIGIT  digit enables, one-hot when active

## Operation
- Shadow regs dig_q[N_DIGIT], dp_q: loaded from DIN/DP_IN on any edge with LOAD=1; held otherwise. Reset to 0.
- HEX_MODE, LZ_BLANK sampled live (not shadowed).
- Scan counter cnt: 0..SCAN_DIV-1, increments every cycle, wraps to 0. On wrap, digit index idx advances; N_DIGIT-1 wraps to 0.
- Segment codes (active-high form, {g..a}): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001, '-'=1000000, blank=0000000.
- Leading-zero blank: digit i blanked iff LZ_BLANK=1, i != 0, and dig_q[j]==0 for all j >= i. Digit 0 never blanked. Blanking affects SEG only; SEG_DP still follows dp_q[i].
- Dead time: while cnt==0, AN all inactive (prevents ghosting); SEG/SEG_DP still driven for current idx.
- Otherwise AN has exactly bit idx active.
- Polarity: SEG/SEG_DP inverted when SEG_ACT_LOW=1; AN inverted when AN_ACT_LOW=1.
- No X on outputs for any input value.

## Timing
- All outputs registered. Output at edge k computed from cnt, idx, dig_q, dp_q, HEX_MODE, LZ_BLANK as held before edge k (one-cycle latency).
- Reset (async assert, sync to CLK on deassert by the board): cnt=0, idx=0, shadows=0, SEG/SEG_DP/AN at inactive levels (all 1 for active-low defaults).
- First cycle after reset release: cnt 0->1; outputs show digit 0 with AN inactive (dead time); AN[0] active from second edge.
- LOAD at edge t: shadow updated at t; SEG reflects new value at edge t+1 if idx selects that digit.
- LOAD coincident with idx advance: the new digit's first output uses the pre-edge shadow; the following cycle uses the new one.
- Full scan period = N_DIGIT*SCAN_DIV cycles; each digit lit SCAN_DIV-1 cycles.
- RST mid-scan: outputs go inactive immediately (asynchronous), scan restarts at digit 0.
- N_DIGIT=1: idx constant 0; dead time still applied each slot.

## Structure
- Package disp_7seg_pkg: segment code constants (CODE_0..CODE_F, CODE_DASH, CODE_BLANK), SEG_W=7, digit width 4.
- Sub-module seg7_hex_enc: combinational 4-bit value + HEX_MODE + blank -> 7-bit active-high code; instantiated once on the selected digit.
- Top holds counter, index, shadows, LZ blanking mask, polarity and output registers.

## Test plan
- Reset then LOAD DIN=16'h1234, DP_IN=0, SCAN_DIV=4 -> sequence over slots: digit0 SEG=~1100110, AN=4'b1110; digit1 ~1001111/1101; digit2 ~1011011/1011; digit3 ~0000110/0111; AN=4'b1111 at each cnt==0 cycle.
- DIN=16'h00A5, HEX_MODE=0, LZ_BLANK=1 -> digit1 shows '-' (~1000000), digits 2,3 blanked (SEG=7'h7F); HEX_MODE=1 -> digit1 ~1110111.
- DIN=16'h0000, LZ_BLANK=1, DP_IN=4'b0100 -> digit0 shows 0 (~0111111); digit2 SEG blank, SEG_DP=0 (lit).
- LOAD pulse with DIN=16'h9876 landing on idx-advance edge -> first cycle of new slot shows old value, next cycle new; no glitch on AN.
- Assert RST mid-slot of digit 2 -> SEG/SEG_DP/AN all 1 same cycle; after release scan resumes at digit 0 with shadows=0.
- SEG_ACT_LOW=0, AN_ACT_LOW=0, N_DIGIT=1 -> AN toggles 0 (dead) then 1; SEG=0111111 for DIN=0.
